pio_in_edge_irq: RTL

Parametrised Avalon-MM input PIO, the successor to the 1-bit polled input port on the Nios Qsys system bus. It captures WIDTH external inputs through a synchroniser, latches per-bit edge events into a sticky capture register and raises a maskable level interrupt to the Nios II. Software reads live data, programs the interrupt mask and clears captured edges with write-1-to-clear.

---
 rtl/pio_in_edge_irq.sv | 118 +++++++++++
 1 files changed

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised inputs, sticky per-bit edge capture with W1C, maskable level irq.
// Optional input debounce is enabled by defining NIOS_PIO_IN_DEBOUNCE_EN.
module pio_in_edge_irq #(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 0,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] w1c;
   logic [31:0]      rd_next;
   logic             wr_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] filtered;

   // Each bit flips only after its mismatch has persisted for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filtered <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_in[i] != filtered[i]) begin
               if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  filtered[i] <= ~filtered[i];
                  cnt[i]      <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign data_in = filtered;
`else
   assign data_in = sync_in;
`endif

   assign rise = data_in & ~d1;
   assign fall = ~data_in & d1;

   always_comb begin
      evt = rise;
      case (EDGE_TYPE)
         1:       evt = fall;
         2:       evt = rise | fall;
         default: evt = rise;
      endcase
   end

   assign wr_en = chipselect & ~write_n;
   assign w1c   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next[WIDTH-1:0] = data_in;
         2'd2:    rd_next[WIDTH-1:0] = irq_mask;
         2'd3:    rd_next[WIDTH-1:0] = edge_capture;
         default: rd_next = '0;
      endcase
   end

   // A new event outranks a W1C of the same bit so no edge is ever lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d1           <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         d1           <= data_in;
         edge_capture <= evt | (edge_capture & ~w1c);
         if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
         readdata     <= rd_next;
         irq          <= |(edge_capture & irq_mask);
      end
   end

endmodule
